// File: rtl/serial_reg_loader_pkg.sv
// Shared frame layout, output FSM encoding and register map for the serial register loader.
package serial_reg_loader_pkg;

  localparam int FRAME_W  = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 5;
  localparam int DATA_MSB = 4;
  localparam int DATA_LSB = 0;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;
  localparam int DATA_W   = DATA_MSB - DATA_LSB + 1;
  localparam int CNT_W    = $clog2(FRAME_W);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } out_state_t;

  // Register map of the downstream signal_generator.
  typedef enum logic [ADDR_W-1:0] {
    REG_PERIOD_A = 3'd0,
    REG_PERIOD_B = 3'd1,
    REG_PERIOD_C = 3'd2,
    REG_NOISE    = 3'd3,
    REG_VOLUME   = 3'd4,
    REG_ENABLE   = 3'd5,
    REG_VIB      = 3'd6
  } reg_addr_t;

  function automatic logic [ADDR_W-1:0] frame_addr(input logic [FRAME_W-1:0] f);
    return f[ADDR_MSB:ADDR_LSB];
  endfunction

  function automatic logic [DATA_W-1:0] frame_data(input logic [FRAME_W-1:0] f);
    return f[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/serial_reg_loader_reg_fifo.sv
// Small synchronous FIFO holding received command frames until the output FSM replays them.
module reg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/serial_reg_loader.sv
// 3-wire serial command receiver: synchronise, deserialise 8-bit frames, queue, and replay
// each frame as a spaced one-cycle register write strobe.
module serial_reg_loader
  import serial_reg_loader_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STROBE_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ser_clk,
  input  logic              ser_data,
  input  logic              ser_cs_n,
  output logic              write_strobe,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              frame_err,
  output logic              overflow,
  output logic              fifo_full
);

  localparam int               GAP_W    = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((STROBE_GAP > 0) ? STROBE_GAP - 1 : 0);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  // ---------------- input synchronisers ----------------
  logic [SYNC_STAGES-1:0] sclk_s;
  logic [SYNC_STAGES-1:0] sdat_s;
  logic [SYNC_STAGES-1:0] scs_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s <= '0;
      sdat_s <= '0;
      scs_s  <= '1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], ser_clk};
      sdat_s <= {sdat_s[SYNC_STAGES-2:0], ser_data};
      scs_s  <= {scs_s[SYNC_STAGES-2:0], ser_cs_n};
    end
  end

  logic sclk_rise;
  logic cs_fall;
  logic cs_rise;
  logic cs_active;
  logic bit_in;
  logic shift_en;

  // Edges compare the last two stages; levels come from the final stage. Using the older cs_n
  // stage lets a bit edge coinciding with cs_n rising still complete its frame.
  assign sclk_rise = sclk_s[SYNC_STAGES-2] & ~sclk_s[SYNC_STAGES-1];
  assign cs_fall   = ~scs_s[SYNC_STAGES-2] & scs_s[SYNC_STAGES-1];
  assign cs_rise   = scs_s[SYNC_STAGES-2] & ~scs_s[SYNC_STAGES-1];
  assign cs_active = ~scs_s[SYNC_STAGES-1];
  assign bit_in    = sdat_s[SYNC_STAGES-1];
  assign shift_en  = sclk_rise & cs_active;

  // ---------------- deserialiser ----------------
  logic [FRAME_W-1:0] shreg;
  logic [CNT_W-1:0]   bit_cnt;
  logic               frame_done;
  logic [FRAME_W-1:0] frame_word;
  logic               partial_at_rise;

  assign frame_done      = shift_en && (bit_cnt == LAST_BIT);
  assign frame_word      = {shreg[FRAME_W-2:0], bit_in};
  assign partial_at_rise = cs_rise && !frame_done && (shift_en || (bit_cnt != '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= partial_at_rise;
      if (cs_fall) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (cs_rise) begin
        shreg   <= frame_word;
        bit_cnt <= '0;
      end else if (shift_en) begin
        shreg   <= frame_word;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // ---------------- frame queue ----------------
  logic [FRAME_W-1:0] fifo_rdata;
  logic               fifo_empty;
  logic               pop;

  reg_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (frame_done),
    .wdata (frame_word),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (frame_done && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // ---------------- output FSM ----------------
  out_state_t       state;
  logic [GAP_W-1:0] gap_cnt;
  logic             out_ready;

  // Pop on the last gap cycle so strobes are exactly 1+STROBE_GAP cycles apart under load.
  assign out_ready = (state == ST_IDLE) ||
                     ((state == ST_STROBE) && (STROBE_GAP == 0)) ||
                     ((state == ST_GAP) && (gap_cnt == '0));
  assign pop       = out_ready & ~fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      write_strobe <= 1'b0;
      address      <= '0;
      data         <= '0;
    end else begin
      write_strobe <= pop;
      if (pop) begin
        state   <= ST_STROBE;
        address <= frame_addr(fifo_rdata);
        data    <= frame_data(fifo_rdata);
      end else begin
        case (state)
          ST_STROBE: begin
            if (STROBE_GAP == 0) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
          ST_GAP: begin
            if (gap_cnt == '0) state <= ST_IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
